instr_exec_unit: RTL and testbench

- Downstream execute stage for the instruction register.
- On a start command, it walks a contiguous range of register locations by driving the register's read pointer.
- It captures each instruction word, computes the result (single-cycle for simple ops, iterative for MULT/DIV/MOD) and emits one result per instruction over a valid/ready handshake.
- The verification scoreboard compares its outputs against the expected ALU model.

---
 rtl/instr_exec_unit_if.sv | 51 +++++
 rtl/instr_exec_unit.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_exec_unit_if.sv
// -----------------------------------------------------------------------------
// instr_exec_unit_if
//   Bundles the command, instruction-register read bus and result channel of
//   the instruction execute stage.
//
//   Instruction word layout (MSB..LSB): {opc[OPC_W], op_a[OPND_W],
//   op_b[OPND_W], rezultat[RES_W]}.
//
//   Signals
//     start, start_addr, count  : run command (count 0..2**ADDR_W)
//     read_pointer              : address to the instruction register
//     instruction_word          : word read back from the instruction register
//     res_valid / res_ready     : result handshake
//     res_addr, res_opc, res_data : result payload
//     busy, done                : run status
//
//   Modports
//     master : the execute unit (drives read_pointer, results and status)
//     slave  : the environment (drives command, instruction word, res_ready)
// -----------------------------------------------------------------------------
interface instr_exec_unit_if #(
  parameter int ADDR_W = 5,
  parameter int OPND_W = 32,
  parameter int RES_W  = 64,
  parameter int OPC_W  = 4
);
  localparam int WORD_W = OPC_W + 2 * OPND_W + RES_W;

  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W-1:0]   read_pointer;
  logic [WORD_W-1:0]   instruction_word;
  logic                res_valid;
  logic                res_ready;
  logic [ADDR_W-1:0]   res_addr;
  logic [OPC_W-1:0]    res_opc;
  logic [RES_W-1:0]    res_data;
  logic                busy;
  logic                done;

  modport master (
    input  start, start_addr, count, instruction_word, res_ready,
    output read_pointer, res_valid, res_addr, res_opc, res_data, busy, done
  );

  modport slave (
    output start, start_addr, count, instruction_word, res_ready,
    input  read_pointer, res_valid, res_addr, res_opc, res_data, busy, done
  );
endinterface

// File: rtl/instr_exec_unit.sv
// -----------------------------------------------------------------------------
// instr_exec_unit
//   Execute stage behind the instruction register. A start command walks
//   count consecutive register locations (wrapping modulo 2**ADDR_W) from
//   start_addr. Each location is fetched, its opcode/operands captured, and
//   one signed result is emitted per instruction over a valid/ready handshake.
//
//   Opcodes (OPC_W = 4): 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT,
//   6 DIV, 7 MOD; any other code yields 0 in a single cycle.
//   MULT/DIV/MOD run on a 32-step iterative engine over operand magnitudes,
//   with the sign applied at the end (DIV truncates toward zero, MOD takes the
//   dividend's sign, divide by zero gives 0).
//
//   Ports
//     clk      : clock, rising edge
//     reset_n  : asynchronous active-low reset (released synchronously)
//     bus      : instr_exec_unit_if.master (command, register bus, results)
//
//   Build option
//     INSTR_EXEC_FAST_MULT_EN : when defined, MULT is a single-cycle
//     combinational multiply and skips the iterative engine. Results are
//     identical in both builds; only MULT latency differs.
// -----------------------------------------------------------------------------
module instr_exec_unit #(
  parameter int ADDR_W = 5,
  parameter int OPND_W = 32,
  parameter int RES_W  = 64,
  parameter int OPC_W  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_exec_unit_if.master   bus
);

  localparam int ITER_W  = $clog2(OPND_W);
  localparam int OPB_LSB = RES_W;
  localparam int OPA_LSB = RES_W + OPND_W;
  localparam int OPC_LSB = RES_W + 2 * OPND_W;
  localparam int EXT_W   = RES_W - OPND_W;

  localparam logic [OPC_W-1:0] OPC_ZERO  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(OPND_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_EXEC,
    S_OUT
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W:0]     remaining_reg, remaining_next;
  logic [ADDR_W-1:0]   rp_reg, rp_next;
  logic [ADDR_W-1:0]   res_addr_reg, res_addr_next;
  logic [OPC_W-1:0]    res_opc_reg, res_opc_next;
  logic [RES_W-1:0]    res_data_reg, res_data_next;
  logic                done_reg, done_next;

  // Iterative engine: shr holds the multiplier (MULT) or the dividend being
  // shifted into the quotient (DIV/MOD).
  logic                sign_a_reg, sign_a_next;
  logic                sign_b_reg, sign_b_next;
  logic                b_zero_reg, b_zero_next;
  logic [RES_W-1:0]    mcand_reg, mcand_next;
  logic [RES_W-1:0]    acc_reg, acc_next;
  logic [OPND_W-1:0]   shr_reg, shr_next;
  logic [OPND_W-1:0]   rem_reg, rem_next;
  logic [OPND_W-1:0]   divisor_reg, divisor_next;
  logic [ITER_W-1:0]   iter_reg, iter_next;

  // ---------------------------------------------------------------------------
  // Instruction word fields
  // ---------------------------------------------------------------------------
  logic [OPC_W-1:0]    w_opc;
  logic [OPND_W-1:0]   w_a, w_b;
  logic [OPND_W-1:0]   w_mag_a, w_mag_b;
  logic [RES_W-1:0]    w_a_ext, w_b_ext;
  logic [RES_W-1:0]    w_simple_res;
  logic                w_iter;
  logic                unused_rezultat;

  assign w_opc = bus.instruction_word[OPC_LSB +: OPC_W];
  assign w_a   = bus.instruction_word[OPA_LSB +: OPND_W];
  assign w_b   = bus.instruction_word[OPB_LSB +: OPND_W];
  assign unused_rezultat = ^bus.instruction_word[RES_W-1:0];

  assign w_a_ext = {{EXT_W{w_a[OPND_W-1]}}, w_a};
  assign w_b_ext = {{EXT_W{w_b[OPND_W-1]}}, w_b};

  // Magnitudes fit unsigned OPND_W bits even for the most negative operand.
  assign w_mag_a = w_a[OPND_W-1] ? (~w_a + 1'b1) : w_a;
  assign w_mag_b = w_b[OPND_W-1] ? (~w_b + 1'b1) : w_b;

`ifdef INSTR_EXEC_FAST_MULT_EN
  assign w_iter = (w_opc == OPC_DIV) || (w_opc == OPC_MOD);
`else
  assign w_iter = (w_opc == OPC_MULT) || (w_opc == OPC_DIV) || (w_opc == OPC_MOD);
`endif

  always_comb begin
    w_simple_res = '0;
    case (w_opc)
      OPC_ZERO:  w_simple_res = '0;
      OPC_PASSA: w_simple_res = w_a_ext;
      OPC_PASSB: w_simple_res = w_b_ext;
      OPC_ADD:   w_simple_res = w_a_ext + w_b_ext;
      OPC_SUB:   w_simple_res = w_a_ext - w_b_ext;
`ifdef INSTR_EXEC_FAST_MULT_EN
      // Low RES_W bits of the sign-extended product equal the signed product.
      OPC_MULT:  w_simple_res = w_a_ext * w_b_ext;
`endif
      default:   w_simple_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of the engine and the sign-corrected final results
  // ---------------------------------------------------------------------------
  logic [RES_W-1:0]    mul_acc_step, mul_mcand_step;
  logic [OPND_W-1:0]   mul_shr_step;
  logic [OPND_W:0]     div_rsh;
  logic                div_ge;
  logic [OPND_W-1:0]   div_rem_step, div_shr_step;
  logic [RES_W-1:0]    q_ext, r_ext;
  logic [RES_W-1:0]    iter_result;

  always_comb begin
    mul_acc_step   = acc_reg + (shr_reg[0] ? mcand_reg : '0);
    mul_mcand_step = mcand_reg << 1;
    mul_shr_step   = shr_reg >> 1;

    // Restoring division: remainder stays below divisor, so the subtraction
    // result always fits in OPND_W bits.
    div_rsh      = {rem_reg, shr_reg[OPND_W-1]};
    div_ge       = (div_rsh >= {1'b0, divisor_reg});
    div_rem_step = div_ge ? (div_rsh[OPND_W-1:0] - divisor_reg) : div_rsh[OPND_W-1:0];
    div_shr_step = {shr_reg[OPND_W-2:0], div_ge};

    q_ext = {{EXT_W{1'b0}}, div_shr_step};
    r_ext = {{EXT_W{1'b0}}, div_rem_step};

    iter_result = '0;
    case (res_opc_reg)
      OPC_MULT: iter_result = (sign_a_reg ^ sign_b_reg) ? (~mul_acc_step + 1'b1) : mul_acc_step;
      OPC_DIV:  iter_result = b_zero_reg ? '0 :
                              ((sign_a_reg ^ sign_b_reg) ? (~q_ext + 1'b1) : q_ext);
      OPC_MOD:  iter_result = b_zero_reg ? '0 :
                              (sign_a_reg ? (~r_ext + 1'b1) : r_ext);
      default:  iter_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    rp_next        = rp_reg;
    res_addr_next  = res_addr_reg;
    res_opc_next   = res_opc_reg;
    res_data_next  = res_data_reg;
    done_next      = 1'b0;
    sign_a_next    = sign_a_reg;
    sign_b_next    = sign_b_reg;
    b_zero_next    = b_zero_reg;
    mcand_next     = mcand_reg;
    acc_next       = acc_reg;
    shr_next       = shr_reg;
    rem_next       = rem_reg;
    divisor_next   = divisor_reg;
    iter_next      = iter_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_next = 1'b1;
          end else begin
            ptr_next       = bus.start_addr;
            remaining_next = bus.count;
            rp_next        = bus.start_addr;
            state_next     = S_FETCH;
          end
        end
      end

      // read_pointer is already stable; this cycle covers the register read.
      S_FETCH: begin
        state_next = S_CAPTURE;
      end

      S_CAPTURE: begin
        res_addr_next = ptr_reg;
        res_opc_next  = w_opc;
        sign_a_next   = w_a[OPND_W-1];
        sign_b_next   = w_b[OPND_W-1];
        b_zero_next   = (w_b == '0);
        mcand_next    = {{EXT_W{1'b0}}, w_mag_a};
        acc_next      = '0;
        shr_next      = (w_opc == OPC_MULT) ? w_mag_b : w_mag_a;
        rem_next      = '0;
        divisor_next  = w_mag_b;
        iter_next     = '0;
        if (w_iter) begin
          state_next = S_EXEC;
        end else begin
          res_data_next = w_simple_res;
          state_next    = S_OUT;
        end
      end

      S_EXEC: begin
        if (res_opc_reg == OPC_MULT) begin
          acc_next   = mul_acc_step;
          mcand_next = mul_mcand_step;
          shr_next   = mul_shr_step;
        end else begin
          rem_next = div_rem_step;
          shr_next = div_shr_step;
        end
        iter_next = iter_reg + 1'b1;
        if (iter_reg == ITER_LAST) begin
          res_data_next = iter_result;
          state_next    = S_OUT;
        end
      end

      S_OUT: begin
        if (bus.res_ready) begin
          ptr_next       = ptr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == (ADDR_W+1)'(1)) begin
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            rp_next    = ptr_reg + 1'b1;
            state_next = S_FETCH;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      rp_reg        <= '0;
      res_addr_reg  <= '0;
      res_opc_reg   <= OPC_ZERO;
      res_data_reg  <= '0;
      done_reg      <= 1'b0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      b_zero_reg    <= 1'b0;
      mcand_reg     <= '0;
      acc_reg       <= '0;
      shr_reg       <= '0;
      rem_reg       <= '0;
      divisor_reg   <= '0;
      iter_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      rp_reg        <= rp_next;
      res_addr_reg  <= res_addr_next;
      res_opc_reg   <= res_opc_next;
      res_data_reg  <= res_data_next;
      done_reg      <= done_next;
      sign_a_reg    <= sign_a_next;
      sign_b_reg    <= sign_b_next;
      b_zero_reg    <= b_zero_next;
      mcand_reg     <= mcand_next;
      acc_reg       <= acc_next;
      shr_reg       <= shr_next;
      rem_reg       <= rem_next;
      divisor_reg   <= divisor_next;
      iter_reg      <= iter_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.read_pointer = rp_reg;
  assign bus.res_valid    = (state_reg == S_OUT);
  assign bus.res_addr     = res_addr_reg;
  assign bus.res_opc      = res_opc_reg;
  assign bus.res_data     = res_data_reg;
  assign bus.busy         = (state_reg != S_IDLE);
  assign bus.done         = done_reg;

endmodule

// File: tb/tb_instr_exec_unit.sv
module tb_instr_exec_unit;

  localparam int WORD_W = 4 + 32 + 32 + 64;

  localparam logic [3:0] ZERO  = 4'd0;
  localparam logic [3:0] PASSA = 4'd1;
  localparam logic [3:0] PASSB = 4'd2;
  localparam logic [3:0] ADD   = 4'd3;
  localparam logic [3:0] SUB   = 4'd4;
  localparam logic [3:0] MULT  = 4'd5;
  localparam logic [3:0] DIV   = 4'd6;
  localparam logic [3:0] MOD   = 4'd7;
  localparam logic [3:0] BAD   = 4'd11;

`ifdef INSTR_EXEC_FAST_MULT_EN
  localparam int MULT_LAT = 3;
`else
  localparam int MULT_LAT = 35;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_exec_unit_if bus ();

  instr_exec_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Instruction register model: one-cycle registered read.
  logic [WORD_W-1:0] mem [32];
  always @(posedge clk) bus.instruction_word <= mem[bus.read_pointer];

  int checks = 0;
  int errors = 0;

  function automatic logic [WORD_W-1:0] mk(input logic [3:0] opc, input logic [31:0] a,
                                           input logic [31:0] b);
    return {opc, a, b, 64'hDEAD_BEEF_CAFE_F00D};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [4:0] addr, input logic [5:0] cnt);
    bus.start      = 1'b1;
    bus.start_addr = addr;
    bus.count      = cnt;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for res_valid; lat is the number of clock edges waited.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
  endtask

  task automatic expect_res(input string tag, input logic [4:0] addr, input logic [3:0] opc,
                            input logic [63:0] data);
    chk({tag, "_addr"}, 64'(bus.res_addr), 64'(addr));
    chk({tag, "_opc"},  64'(bus.res_opc),  64'(opc));
    chk({tag, "_data"}, bus.res_data, data);
    $display("result %s addr=%0d opc=%0d data=%0h", tag, bus.res_addr, bus.res_opc, bus.res_data);
  endtask

  logic [63:0] exp_c [7];
  logic [4:0]  a5;
  int lat;
  int bad;

  initial begin
    bus.start            = 1'b0;
    bus.start_addr       = '0;
    bus.count            = '0;
    bus.res_ready        = 1'b1;
    bus.instruction_word = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_rp",    64'(bus.read_pointer), 64'd0);
    chk("rst_data",  bus.res_data, 64'd0);
    chk("rst_opc",   64'(bus.res_opc), 64'(ZERO));
    chk("rst_done",  64'(bus.done), 64'd0);
    reset_n = 1'b1;
    tick();

    // ---------------- simple ops, addresses 0..2 ----------------
    mem[0] = mk(ADD, 32'd5, 32'd3);
    mem[1] = mk(SUB, -32'sd7, 32'd4);
    mem[2] = mk(PASSB, 32'd0, 32'd9);
    bus.res_ready = 1'b1;
    start_run(5'd0, 6'd3);
    chk("a_busy", 64'(bus.busy), 64'd1);
    wait_valid("a0", lat);
    chk("a0_latency", 64'(lat + 1), 64'd3);
    expect_res("a0", 5'd0, ADD, 64'd8);
    tick();
    wait_valid("a1", lat);
    expect_res("a1", 5'd1, SUB, -64'sd11);
    tick();
    wait_valid("a2", lat);
    expect_res("a2", 5'd2, PASSB, 64'd9);
    tick();
    chk("a_done", 64'(bus.done), 64'd1);
    chk("a_idle", 64'(bus.busy), 64'd0);
    chk("a_rp_hold", 64'(bus.read_pointer), 64'd2);
    tick();
    chk("a_done_pulse", 64'(bus.done), 64'd0);

    // ---------------- MULT at 31, DIV at 0 (wrap) ----------------
    mem[31] = mk(MULT, -32'sd15, 32'd15);
    mem[0]  = mk(DIV, -32'sd15, 32'd4);
    start_run(5'd31, 6'd2);
    wait_valid("b0", lat);
    chk("b0_latency", 64'(lat + 1), 64'(MULT_LAT));
    expect_res("b0", 5'd31, MULT, -64'sd225);
    tick();
    chk("b_rp_wrap", 64'(bus.read_pointer), 64'd0);
    wait_valid("b1", lat);
    chk("b1_latency", 64'(lat), 64'd34);
    expect_res("b1", 5'd0, DIV, -64'sd3);
    tick();
    chk("b_done", 64'(bus.done), 64'd1);

    // ---------------- MOD, divide by zero, unknown op, extremes ----------------
    mem[3] = mk(MOD, -32'sd15, 32'd4);
    mem[4] = mk(DIV, 32'd12, 32'd0);
    mem[5] = mk(MOD, 32'd12, 32'd0);
    mem[6] = mk(BAD, 32'd5, 32'd6);
    mem[7] = mk(MULT, 32'h8000_0000, 32'h8000_0000);
    mem[8] = mk(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    mem[9] = mk(PASSA, 32'hFFFF_FFFF, 32'd0);
    exp_c[0] = -64'sd3;
    exp_c[1] = 64'd0;
    exp_c[2] = 64'd0;
    exp_c[3] = 64'd0;
    exp_c[4] = 64'h4000_0000_0000_0000;
    exp_c[5] = 64'h0000_0000_8000_0000;
    exp_c[6] = 64'hFFFF_FFFF_FFFF_FFFF;
    start_run(5'd3, 6'd7);
    for (int k = 0; k < 7; k++) begin
      a5 = 5'(3 + k);
      wait_valid($sformatf("c%0d", k), lat);
      if (k == 3) chk("c3_unknown_latency", 64'(lat), 64'd2);
      expect_res($sformatf("c%0d", k), a5, mem[a5][131:128], exp_c[k]);
      tick();
    end
    chk("c_done", 64'(bus.done), 64'd1);

    // ---------------- back-pressure with ignored start ----------------
    mem[10] = mk(ADD, 32'd100, 32'hFFFF_FFFF);
    mem[11] = mk(SUB, 32'd1, 32'd2);
    bus.res_ready = 1'b0;
    start_run(5'd10, 6'd2);
    wait_valid("d0", lat);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        bus.start      = 1'b1;
        bus.start_addr = 5'd20;
        bus.count      = 6'd5;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_data !== 64'd99 ||
          bus.res_addr !== 5'd10 || bus.read_pointer !== 5'd10) bad++;
    end
    bus.start = 1'b0;
    chk("d_hold_unstable_cycles", 64'(bad), 64'd0);
    expect_res("d0", 5'd10, ADD, 64'd99);
    bus.res_ready = 1'b1;
    tick();
    wait_valid("d1", lat);
    expect_res("d1", 5'd11, SUB, -64'sd1);
    tick();
    chk("d_done", 64'(bus.done), 64'd1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) bad++;
    end
    chk("d_start_ignored", 64'(bad), 64'd0);

    // ---------------- count == 0 ----------------
    start_run(5'd9, 6'd0);
    chk("z_done", 64'(bus.done), 64'd1);
    chk("z_busy", 64'(bus.busy), 64'd0);
    chk("z_valid", 64'(bus.res_valid), 64'd0);
    tick();
    chk("z_done_pulse", 64'(bus.done), 64'd0);

    // ---------------- count == 32 from address 5 ----------------
    for (int i = 0; i < 32; i++) mem[i] = mk(ADD, 32'(i), 32'd1000);
    start_run(5'd5, 6'd32);
    for (int k = 0; k < 32; k++) begin
      a5 = 5'(5 + k);
      wait_valid($sformatf("f%0d", k), lat);
      expect_res($sformatf("f%0d", k), a5, ADD, 64'(32'(a5) + 1000));
      tick();
    end
    chk("f_done", 64'(bus.done), 64'd1);

    // ---------------- reset during EXEC ----------------
    mem[7] = mk(DIV, 32'd100, 32'd7);
    start_run(5'd7, 6'd1);
    for (int c = 0; c < 10; c++) tick();
    chk("r_busy_before", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("r_busy",  64'(bus.busy), 64'd0);
    chk("r_valid", 64'(bus.res_valid), 64'd0);
    chk("r_rp",    64'(bus.read_pointer), 64'd0);
    chk("r_addr",  64'(bus.res_addr), 64'd0);
    chk("r_data",  bus.res_data, 64'd0);
    chk("r_opc",   64'(bus.res_opc), 64'(ZERO));
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("r_no_valid_after", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
